// File: rtl/ok_dual_pipe_host.sv
// Two-channel host bridge: each channel has one pipe-in and one pipe-out
// endpoint plus a read-only transfer-count register.
module ok_pipe_chan #(
  parameter logic [7:0] PIPE_IN_ADDR  = 8'h80,
  parameter logic [7:0] PIPE_OUT_ADDR = 8'hA0,
  parameter logic [7:0] STATUS_ADDR   = 8'h3E
) (
  input  logic        okClk,
  input  logic        reset,
  input  logic        valid,
  input  logic        write,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic [31:0] pin_dataout,
  output logic        pin_write,
  input  logic [31:0] pout_datain,
  output logic        pout_read
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_W1,
    S_W2
  } st_t;

  st_t         st;
  st_t         st_nxt;
  logic        acc;
  logic        acc_pin;
  logic        acc_pout;
  logic        rd_done;
  logic [7:0]  rd_addr;
  logic [15:0] pin_count;
  logic [15:0] pout_count;

  assign acc      = valid & ready;
  assign acc_pin  = acc & write & (addr == PIPE_IN_ADDR);
  assign acc_pout = acc & ~write & (addr == PIPE_OUT_ADDR);

  // Read-sequencer state register
  always_ff @(posedge okClk) begin
    if (reset) st <= S_IDLE;
    else       st <= st_nxt;
  end

  // Next state: accept -> wait for user data -> sample and complete
  always_comb begin
    st_nxt = st;
    unique case (st)
      S_IDLE: if (acc && !write) st_nxt = S_W1;
      S_W1:   st_nxt = S_W2;
      S_W2:   st_nxt = S_IDLE;
      default: st_nxt = S_IDLE;
    endcase
  end

  // Ready drops while a read is outstanding; completion in last phase
  always_comb begin
    ready   = (st == S_IDLE);
    rd_done = (st == S_W2);
  end

  // Strobes, counters, pipe-in data and read-data capture
  always_ff @(posedge okClk) begin
    if (reset) begin
      pin_write   <= 1'b0;
      pout_read   <= 1'b0;
      rvalid      <= 1'b0;
      pin_dataout <= '0;
      rdata       <= '0;
      rd_addr     <= '0;
      pin_count   <= '0;
      pout_count  <= '0;
    end else begin
      pin_write <= acc_pin;
      pout_read <= acc_pout;
      rvalid    <= rd_done;
      if (acc_pin) begin
        pin_dataout <= wdata;
        pin_count   <= pin_count + 16'd1;
      end
      if (acc_pout) pout_count <= pout_count + 16'd1;
      if (acc && !write) rd_addr <= addr;
      if (rd_done) begin
        unique case (1'b1)
          (rd_addr == PIPE_OUT_ADDR): rdata <= pout_datain;
          (rd_addr == STATUS_ADDR):   rdata <= {pout_count, pin_count};
          default:                    rdata <= '0;
        endcase
      end
    end
  end

endmodule

module ok_dual_pipe_host #(
  parameter logic [7:0] PIPE_IN_ADDR  = 8'h80,
  parameter logic [7:0] PIPE_OUT_ADDR = 8'hA0,
  parameter logic [7:0] STATUS_ADDR   = 8'h3E
) (
  input  logic        okClk,
  input  logic        reset,
  input  logic        hp_valid,
  input  logic        hp_write,
  input  logic [7:0]  hp_addr,
  input  logic [31:0] hp_wdata,
  output logic        hp_ready,
  output logic [31:0] hp_rdata,
  output logic        hp_rvalid,
  input  logic        hs_valid,
  input  logic        hs_write,
  input  logic [7:0]  hs_addr,
  input  logic [31:0] hs_wdata,
  output logic        hs_ready,
  output logic [31:0] hs_rdata,
  output logic        hs_rvalid,
  output logic [31:0] pinp_dataout,
  output logic        pinp_write,
  output logic [31:0] pins_dataout,
  output logic        pins_write,
  input  logic [31:0] poutp_datain,
  output logic        poutp_read,
  input  logic [31:0] pouts_datain,
  output logic        pouts_read
);

  ok_pipe_chan #(
    .PIPE_IN_ADDR (PIPE_IN_ADDR),
    .PIPE_OUT_ADDR(PIPE_OUT_ADDR),
    .STATUS_ADDR  (STATUS_ADDR)
  ) u_p (
    .okClk      (okClk),
    .reset      (reset),
    .valid      (hp_valid),
    .write      (hp_write),
    .addr       (hp_addr),
    .wdata      (hp_wdata),
    .ready      (hp_ready),
    .rdata      (hp_rdata),
    .rvalid     (hp_rvalid),
    .pin_dataout(pinp_dataout),
    .pin_write  (pinp_write),
    .pout_datain(poutp_datain),
    .pout_read  (poutp_read)
  );

  ok_pipe_chan #(
    .PIPE_IN_ADDR (PIPE_IN_ADDR),
    .PIPE_OUT_ADDR(PIPE_OUT_ADDR),
    .STATUS_ADDR  (STATUS_ADDR)
  ) u_s (
    .okClk      (okClk),
    .reset      (reset),
    .valid      (hs_valid),
    .write      (hs_write),
    .addr       (hs_addr),
    .wdata      (hs_wdata),
    .ready      (hs_ready),
    .rdata      (hs_rdata),
    .rvalid     (hs_rvalid),
    .pin_dataout(pins_dataout),
    .pin_write  (pins_write),
    .pout_datain(pouts_datain),
    .pout_read  (pouts_read)
  );

endmodule

// File: tb/tb_ok_dual_pipe_host.sv
// Scoreboard bench for ok_dual_pipe_host: expectations are queued as
// requests are driven and popped when strobes or read data appear.
module tb_ok_dual_pipe_host;

  logic        okClk = 1'b0;
  logic        reset = 1'b1;
  logic        hp_valid = 1'b0, hp_write = 1'b0;
  logic [7:0]  hp_addr = '0;
  logic [31:0] hp_wdata = '0;
  logic        hs_valid = 1'b0, hs_write = 1'b0;
  logic [7:0]  hs_addr = '0;
  logic [31:0] hs_wdata = '0;
  logic        hp_ready, hp_rvalid, hs_ready, hs_rvalid;
  logic [31:0] hp_rdata, hs_rdata;
  logic [31:0] pinp_dataout, pins_dataout;
  logic        pinp_write, pins_write, poutp_read, pouts_read;
  logic [31:0] poutp_datain = '0, pouts_datain = '0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] pq_w[$], sq_w[$], pq_r[$], sq_r[$];
  logic [15:0] p_pin, p_pout, s_pin, s_pout;
  logic [31:0] p_ud, s_ud;
  int p_rd_seen, s_rd_seen;

  ok_dual_pipe_host dut (
    .okClk(okClk), .reset(reset),
    .hp_valid(hp_valid), .hp_write(hp_write),
    .hp_addr(hp_addr), .hp_wdata(hp_wdata),
    .hp_ready(hp_ready), .hp_rdata(hp_rdata),
    .hp_rvalid(hp_rvalid),
    .hs_valid(hs_valid), .hs_write(hs_write),
    .hs_addr(hs_addr), .hs_wdata(hs_wdata),
    .hs_ready(hs_ready), .hs_rdata(hs_rdata),
    .hs_rvalid(hs_rvalid),
    .pinp_dataout(pinp_dataout), .pinp_write(pinp_write),
    .pins_dataout(pins_dataout), .pins_write(pins_write),
    .poutp_datain(poutp_datain), .poutp_read(poutp_read),
    .pouts_datain(pouts_datain), .pouts_read(pouts_read)
  );

  always #5 okClk = ~okClk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // User-side model: present new pipe-out data one edge after the strobe
  always @(posedge okClk) begin
    if (poutp_read) poutp_datain <= p_ud;
    if (pouts_read) pouts_datain <= s_ud;
  end

  // Output monitor
  always @(negedge okClk) begin
    if (!reset) begin
      if (pinp_write) begin
        if (pq_w.size() == 0) chk("p_unexp_write", 1, 0);
        else chk("p_wdata", pinp_dataout, pq_w.pop_front());
      end
      if (pins_write) begin
        if (sq_w.size() == 0) chk("s_unexp_write", 1, 0);
        else chk("s_wdata", pins_dataout, sq_w.pop_front());
      end
      if (hp_rvalid) begin
        if (pq_r.size() == 0) chk("p_unexp_rvalid", 1, 0);
        else chk("p_rdata", hp_rdata, pq_r.pop_front());
      end
      if (hs_rvalid) begin
        if (sq_r.size() == 0) chk("s_unexp_rvalid", 1, 0);
        else chk("s_rdata", hs_rdata, sq_r.pop_front());
      end
      if (poutp_read) p_rd_seen++;
      if (pouts_read) s_rd_seen++;
    end
  end

  function automatic logic [31:0] rd_exp(input logic [7:0] a,
                                         input logic [31:0] ud,
                                         input logic [15:0] pin,
                                         input logic [15:0] pout);
    if (a == 8'hA0) return ud;
    if (a == 8'h3E) return {pout, pin};
    return 32'h0;
  endfunction

  // Drive one request starting at a negedge; returns one negedge later
  task automatic req(input int ch, input logic wr,
                     input logic [7:0] a, input logic [31:0] d,
                     input logic [31:0] ud);
    int n;
    n = 0;
    while ((ch == 0) ? !hp_ready : !hs_ready) begin
      @(negedge okClk);
      n++;
      if (n > 20) begin
        chk("ready_timeout", 0, 1);
        return;
      end
    end
    if (ch == 0) begin
      hp_valid = 1'b1; hp_write = wr; hp_addr = a; hp_wdata = d;
      if (wr && a == 8'h80) begin
        pq_w.push_back(d); p_pin++;
      end
      if (!wr) begin
        p_ud = ud;
        pq_r.push_back(rd_exp(a, ud, p_pin, p_pout));
        if (a == 8'hA0) p_pout++;
      end
    end else begin
      hs_valid = 1'b1; hs_write = wr; hs_addr = a; hs_wdata = d;
      if (wr && a == 8'h80) begin
        sq_w.push_back(d); s_pin++;
      end
      if (!wr) begin
        s_ud = ud;
        sq_r.push_back(rd_exp(a, ud, s_pin, s_pout));
        if (a == 8'hA0) s_pout++;
      end
    end
    @(negedge okClk);
    if (ch == 0) hp_valid = 1'b0;
    else         hs_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge okClk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hp_valid = 1'b0;
    hs_valid = 1'b0;
    idle(2);
    pq_w.delete(); sq_w.delete(); pq_r.delete(); sq_r.delete();
    p_pin = '0; p_pout = '0; s_pin = '0; s_pout = '0;
    p_rd_seen = 0; s_rd_seen = 0;
    reset = 1'b0;
  endtask

  initial begin
    p_ud = '0; s_ud = '0;
    @(negedge okClk);
    do_reset();

    chk("rst_hp_ready", {31'b0, hp_ready}, 1);
    chk("rst_hs_ready", {31'b0, hs_ready}, 1);
    chk("rst_strobes",
        {28'b0, pinp_write, pins_write, poutp_read, pouts_read}, 0);
    chk("rst_rvalid", {30'b0, hp_rvalid, hs_rvalid}, 0);
    chk("rst_hp_rdata", hp_rdata, 0);
    chk("rst_hs_rdata", hs_rdata, 0);
    chk("rst_pinp_data", pinp_dataout, 0);
    req(0, 1'b0, 8'h3E, 0, 0);
    idle(3);

    req(0, 1'b1, 8'h80, 32'hDEADBEEF, 0);
    chk("p_wr_strobe", {31'b0, pinp_write}, 1);
    idle(1);
    chk("p_wr_one_cycle", {31'b0, pinp_write}, 0);
    chk("p_wr_hold", pinp_dataout, 32'hDEADBEEF);
    chk("s_untouched", pins_dataout, 0);
    req(0, 1'b1, 8'h81, 32'h0BAD0BAD, 0);
    req(0, 1'b1, 8'hA0, 32'h0BAD0BAD, 0);
    idle(2);
    chk("p_ignored_hold", pinp_dataout, 32'hDEADBEEF);

    req(0, 1'b0, 8'hA0, 0, 32'h12345678);
    chk("p_rd_ready0", {31'b0, hp_ready}, 0);
    chk("p_rd_strobe", {31'b0, poutp_read}, 1);
    idle(1);
    chk("p_rd_ready1", {31'b0, hp_ready}, 0);
    chk("p_rd_one_cycle", {31'b0, poutp_read}, 0);
    idle(1);
    chk("p_rd_ready2", {31'b0, hp_ready}, 1);
    chk("p_rd_rvalid", {31'b0, hp_rvalid}, 1);
    idle(1);
    chk("p_rvalid_pulse", {31'b0, hp_rvalid}, 0);
    chk("p_rdata_hold", hp_rdata, 32'h12345678);

    fork
      req(0, 1'b1, 8'h80, 32'h1, 0);
      req(1, 1'b0, 8'hA0, 0, 32'h55AA55AA);
    join
    chk("sim_strobes", {30'b0, pinp_write, pouts_read}, 2'b11);
    idle(3);

    for (int i = 0; i < 4; i++)
      req(0, 1'b1, 8'h80, 32'hA000_0000 + 32'(i), 0);
    idle(2);

    do_reset();
    for (int i = 0; i < 65537; i++)
      req(0, 1'b1, 8'h80, 32'(i), 0);
    for (int i = 0; i < 3; i++)
      req(0, 1'b0, 8'hA0, 0, 32'hC0DE_0000 + 32'(i));
    req(0, 1'b0, 8'h3E, 0, 0);
    idle(3);
    chk("wrap_status", hp_rdata, 32'h0003_0001);
    req(0, 1'b0, 8'h10, 0, 0);
    idle(2);
    chk("other_addr_rdata", hp_rdata, 0);
    chk("p_pout_strobes", p_rd_seen, 3);
    req(1, 1'b0, 8'h3E, 0, 0);
    idle(3);

    req(0, 1'b0, 8'hA0, 0, 32'hFEEDFACE);
    void'(pq_r.pop_back());
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    pq_w.delete(); pq_r.delete();
    chk("abort_ready", {31'b0, hp_ready}, 1);
    chk("abort_rdata", hp_rdata, 0);
    idle(4);
    chk("abort_no_strobe", {31'b0, poutp_read}, 0);

    chk("pq_w_empty", pq_w.size(), 0);
    chk("sq_w_empty", sq_w.size(), 0);
    chk("pq_r_empty", pq_r.size(), 0);
    chk("sq_r_empty", sq_r.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
